alu_sequencer: RTL and testbench

//   Fetch/decode/execute controller for the 4-bit ALU: steps through a 16-word program memory.

---
 rtl/alu_pkg.sv | 51 +++++
 rtl/alu_decode.sv | 50 +++++
 rtl/alu_sequencer.sv | 149 ++++++++++++++
 tb/tb_alu_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the ALU sequencer: opcodes, ALU
//               operation select codes, FSM state encoding and flag bit
//               positions inside the {V,Z,C} flag register.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Program-word opcodes (instr[7:4])
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_NOT  = 4'h5;
    localparam logic [3:0] OP_SHL2 = 4'h6;
    localparam logic [3:0] OP_SHR2 = 4'h7;
    localparam logic [3:0] OP_LDI  = 4'h8;
    localparam logic [3:0] OP_JZ   = 4'h9;
    localparam logic [3:0] OP_JC   = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    // ALU operation select codes
    localparam logic [3:0] ALU_NONE = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0001;
    localparam logic [3:0] ALU_SUB  = 4'b0010;
    localparam logic [3:0] ALU_AND  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_NOT  = 4'b0111;
    localparam logic [3:0] ALU_SHL  = 4'b1000;
    localparam logic [3:0] ALU_SHR  = 4'b1100;

    // Flag register bit positions: flags = {V,Z,C}
    localparam int FLAG_V = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 0;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_decode.sv
`default_nettype none
// ============================================================================
// Module      : alu_decode
// Description : Combinational opcode decoder. Maps an opcode to the ALU
//               operation select and classifies it as ALU / jump / load-
//               immediate / halt. Undefined opcodes decode as NOP.
// Ports       : opcode   in  4  instruction opcode field
//               alu_ctrl out 4  ALU select (0000 for non-ALU opcodes)
//               is_alu   out 1  ALU operation needing writeback
//               is_jump  out 1  JZ / JC / JMP
//               is_ldi   out 1  load immediate
//               is_halt  out 1  halt
// Revision    : 1.0 - initial release
// ============================================================================
module alu_decode
    import alu_pkg::*;
(
    input  logic [3:0] opcode,
    output logic [3:0] alu_ctrl,
    output logic       is_alu,
    output logic       is_jump,
    output logic       is_ldi,
    output logic       is_halt
);

    always_comb begin
        alu_ctrl = ALU_NONE;
        is_alu   = 1'b0;
        is_jump  = 1'b0;
        is_ldi   = 1'b0;
        is_halt  = 1'b0;
        case (opcode)
            OP_ADD:  begin alu_ctrl = ALU_ADD; is_alu = 1'b1; end
            OP_SUB:  begin alu_ctrl = ALU_SUB; is_alu = 1'b1; end
            OP_AND:  begin alu_ctrl = ALU_AND; is_alu = 1'b1; end
            OP_OR:   begin alu_ctrl = ALU_OR;  is_alu = 1'b1; end
            OP_NOT:  begin alu_ctrl = ALU_NOT; is_alu = 1'b1; end
            OP_SHL2: begin alu_ctrl = ALU_SHL; is_alu = 1'b1; end
            OP_SHR2: begin alu_ctrl = ALU_SHR; is_alu = 1'b1; end
            OP_LDI:  is_ldi  = 1'b1;
            OP_JZ,
            OP_JC,
            OP_JMP:  is_jump = 1'b1;
            OP_HALT: is_halt = 1'b1;
            default: ;
        endcase
    end

endmodule : alu_decode
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_sequencer
// Description : Fetch/decode/execute controller for a 4-bit ALU. Steps
//               through a synchronous program ROM, drives the ALU and
//               latches its result into an accumulator and flag register.
// Ports       : clk, reset          clock, synchronous active-high reset
//               start               begin execution from pc=0 (IDLE only)
//               pc / instr          ROM address / ROM word (1-cycle latency)
//               ALU_control/Ain/Bin ALU operation and operands
//               ACC_out, V, Z, C    ALU result and flags
//               acc, flags          accumulator, latched {V,Z,C}
//               busy, halted        FETCH..WRITEBACK / HALT status
// Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int PC_W   = 4,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [PC_W-1:0]   pc,
    input  logic [7:0]        instr,
    output logic [3:0]        ALU_control,
    output logic [DATA_W-1:0] Ain,
    output logic [DATA_W-1:0] Bin,
    input  logic [DATA_W-1:0] ACC_out,
    input  logic              V,
    input  logic              Z,
    input  logic              C,
    output logic [DATA_W-1:0] acc,
    output logic [2:0]        flags,
    output logic              busy,
    output logic              halted
);

    state_t            state, state_n;
    logic [PC_W-1:0]   pc_n, pc_inc;
    logic [DATA_W-1:0] acc_n;
    logic [2:0]        flags_n;
    logic [7:0]        ir, ir_n;

    logic [3:0] dec_ctrl;
    logic       is_alu, is_jump, is_ldi, is_halt;
    logic       jump_taken;

    alu_decode u_decode (
        .opcode   (ir[7:4]),
        .alu_ctrl (dec_ctrl),
        .is_alu   (is_alu),
        .is_jump  (is_jump),
        .is_ldi   (is_ldi),
        .is_halt  (is_halt)
    );

    // Wraps naturally modulo 2**PC_W
    assign pc_inc = pc + PC_W'(1);

    // Conditional jumps test the latched flags, never the live ALU outputs
    always_comb begin
        jump_taken = 1'b0;
        case (ir[7:4])
            OP_JZ:   jump_taken = flags[FLAG_Z];
            OP_JC:   jump_taken = flags[FLAG_C];
            OP_JMP:  jump_taken = 1'b1;
            default: jump_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        acc_n   = acc;
        flags_n = flags;
        ir_n    = ir;
        case (state)
            ST_IDLE: begin
                if (start) state_n = ST_FETCH;
            end
            ST_FETCH: begin
                state_n = ST_DECODE;
            end
            ST_DECODE: begin
                // ROM word for the pc presented in FETCH is valid now
                ir_n    = instr;
                state_n = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (is_alu) begin
                    state_n = ST_WRITEBACK;
                end else if (is_halt) begin
                    state_n = ST_HALT;
                end else if (is_ldi) begin
                    acc_n   = DATA_W'(ir[3:0]);
                    pc_n    = pc_inc;
                    state_n = ST_FETCH;
                end else if (is_jump) begin
                    pc_n    = jump_taken ? PC_W'(ir[3:0]) : pc_inc;
                    state_n = ST_FETCH;
                end else begin
                    pc_n    = pc_inc;
                    state_n = ST_FETCH;
                end
            end
            ST_WRITEBACK: begin
                acc_n   = ACC_out;
                flags_n = {V, Z, C};
                pc_n    = pc_inc;
                state_n = ST_FETCH;
            end
            ST_HALT: begin
                state_n = ST_HALT;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            pc    <= '0;
            acc   <= '0;
            flags <= '0;
            ir    <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            acc   <= acc_n;
            flags <= flags_n;
            ir    <= ir_n;
        end
    end

    // ir and acc are held across EXECUTE and WRITEBACK, so the ALU inputs
    // and select stay stable while the result is captured.
    assign ALU_control = (state == ST_EXECUTE || state == ST_WRITEBACK) ? dec_ctrl : ALU_NONE;
    assign Ain         = acc;
    assign Bin         = DATA_W'(ir[3:0]);
    assign busy        = (state == ST_FETCH)   || (state == ST_DECODE) ||
                         (state == ST_EXECUTE) || (state == ST_WRITEBACK);
    assign halted      = (state == ST_HALT);

endmodule : alu_sequencer
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_sequencer
// Description : Directed self-checking bench for alu_sequencer with a
//               behavioural 4-bit ALU and a synchronous 16-word ROM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] pc;
    logic [7:0] instr;
    logic [3:0] alu_control;
    logic [3:0] ain, bin, acc_out, acc;
    logic       v, z, c;
    logic [2:0] flags;
    logic       busy, halted;

    logic [7:0] rom [16];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.PC_W(4), .DATA_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .pc          (pc),
        .instr       (instr),
        .ALU_control (alu_control),
        .Ain         (ain),
        .Bin         (bin),
        .ACC_out     (acc_out),
        .V           (v),
        .Z           (z),
        .C           (c),
        .acc         (acc),
        .flags       (flags),
        .busy        (busy),
        .halted      (halted)
    );

    // Synchronous ROM: word appears one cycle after its address
    always_ff @(posedge clk) instr <= rom[pc];

    // Reference ALU
    logic [4:0] wide;
    logic [3:0] res;
    always_comb begin
        wide = 5'd0;
        res  = 4'd0;
        v    = 1'b0;
        c    = 1'b0;
        case (alu_control)
            4'b0001: begin
                wide = {1'b0, ain} + {1'b0, bin};
                res  = wide[3:0];
                c    = wide[4];
                v    = (ain[3] == bin[3]) && (res[3] != ain[3]);
            end
            4'b0010: begin
                res = ain - bin;
                c   = (ain < bin);
                v   = (ain[3] != bin[3]) && (res[3] != ain[3]);
            end
            4'b0101: res = ain & bin;
            4'b0110: res = ain | bin;
            4'b0111: res = ~ain;
            4'b1000: res = ain << 2;
            4'b1100: res = ain >> 2;
            default: res = 4'd0;
        endcase
        acc_out = res;
        z       = (res == 4'd0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic load(input logic [7:0] w0, input logic [7:0] w1,
                        input logic [7:0] w2, input logic [7:0] w3,
                        input logic [7:0] w4);
        for (int i = 0; i < 16; i++) rom[i] = 8'hF0;
        rom[0] = w0; rom[1] = w1; rom[2] = w2; rom[3] = w3; rom[4] = w4;
    endtask

    // Counts edges (including the one that samples start) until HALT
    task automatic run_to_halt(input string tag, output int n);
        n = 0;
        while (!halted && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_halted"}, 32'(halted), 32'd1);
    endtask

    // Waits for the next ALU instruction, checks its select and duration
    // (EXECUTE + WRITEBACK) and the accumulator once it has retired
    task automatic alu_step(input string tag, input logic [3:0] exp_ctrl, input logic [3:0] exp_acc);
        int n = 0;
        while (alu_control == 4'd0 && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_ctrl"}, 32'(alu_control), 32'(exp_ctrl));
        n = 0;
        while (alu_control != 4'd0 && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_len"}, 32'(n), 32'd2);
        chk({tag, "_acc"}, 32'(acc), 32'(exp_acc));
    endtask

    initial begin
        int n;
        reset = 1'b1;
        start = 1'b0;
        load(8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0);
        do_reset();

        // Reset state
        chk("rst_pc",     32'(pc),          32'd0);
        chk("rst_acc",    32'(acc),         32'd0);
        chk("rst_flags",  32'(flags),       32'd0);
        chk("rst_ctrl",   32'(alu_control), 32'd0);
        chk("rst_busy",   32'(busy),        32'd0);
        chk("rst_halted", 32'(halted),      32'd0);
        tick();
        chk("idle_hold",  32'(busy),        32'd0);

        // 1: LDI 3, ADD 2, HALT; start held high throughout
        load(8'h83, 8'h12, 8'hF0, 8'hF0, 8'hF0);
        start = 1'b1;
        run_to_halt("t1", n);
        chk("t1_cycles", 32'(n),     32'd11);
        chk("t1_acc",    32'(acc),   32'd5);
        chk("t1_flags",  32'(flags), 32'd0);
        chk("t1_pc",     32'(pc),    32'd2);
        chk("t1_busy",   32'(busy),  32'd0);
        tick(); tick(); tick();
        chk("t1_hold_pc",     32'(pc),     32'd2);
        chk("t1_hold_halted", 32'(halted), 32'd1);
        start = 1'b0;

        // 2: LDI F, ADD 1 -> 0 with Z,C; JZ 5 taken
        do_reset();
        load(8'h8F, 8'h11, 8'h95, 8'hF0, 8'hF0);
        rom[5] = 8'hF0;
        start = 1'b1;
        tick();
        start = 1'b0;
        alu_step("t2_add", 4'b0001, 4'h0);
        chk("t2_flags", 32'(flags), 32'b011);
        run_to_halt("t2", n);
        chk("t2_pc", 32'(pc), 32'd5);

        // 3: LDI 1, SUB 1 -> Z=1, C=0; JC not taken
        do_reset();
        load(8'h81, 8'h21, 8'hA0, 8'hF0, 8'hF0);
        start = 1'b1;
        tick();
        start = 1'b0;
        alu_step("t3_sub", 4'b0010, 4'h0);
        chk("t3_flags", 32'(flags), 32'b010);
        run_to_halt("t3", n);
        chk("t3_pc", 32'(pc), 32'd3);

        // 4: LDI 6, SHL2, SHR2, NOT
        do_reset();
        load(8'h86, 8'h60, 8'h70, 8'h50, 8'hF0);
        start = 1'b1;
        tick();
        start = 1'b0;
        alu_step("t4_shl", 4'b1000, 4'h8);
        chk("t4_shl_z", 32'(flags[1]), 32'd0);
        alu_step("t4_shr", 4'b1100, 4'h2);
        chk("t4_shr_z", 32'(flags[1]), 32'd0);
        alu_step("t4_not", 4'b0111, 4'hD);
        chk("t4_not_z", 32'(flags[1]), 32'd0);
        run_to_halt("t4", n);
        chk("t4_pc", 32'(pc), 32'd4);

        // 5: JMP F at 0, NOP at F -> pc wraps to 0 and loops forever
        do_reset();
        load(8'hBF, 8'hF0, 8'hF0, 8'hF0, 8'hF0);
        rom[15] = 8'h00;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (pc != 4'hF && n < 50) begin tick(); n++; end
        chk("t5_pc_f", 32'(pc), 32'hF);
        n = 0;
        while (pc != 4'h0 && n < 50) begin tick(); n++; end
        chk("t5_pc_wrap", 32'(pc), 32'h0);
        n = 0;
        while (pc != 4'hF && n < 50) begin tick(); n++; end
        chk("t5_pc_again", 32'(pc), 32'hF);
        chk("t5_busy",     32'(busy),   32'd1);
        chk("t5_halted",   32'(halted), 32'd0);

        // 6: reset during EXECUTE of ADD, then rerun
        do_reset();
        load(8'h83, 8'h12, 8'hF0, 8'hF0, 8'hF0);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (alu_control != 4'b0001 && n < 50) begin tick(); n++; end
        chk("t6_exec_acc", 32'(acc), 32'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_busy",  32'(busy),        32'd0);
        chk("t6_acc",   32'(acc),         32'd0);
        chk("t6_flags", 32'(flags),       32'd0);
        chk("t6_ctrl",  32'(alu_control), 32'd0);
        chk("t6_pc",    32'(pc),          32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        run_to_halt("t6", n);
        chk("t6_rerun_acc", 32'(acc), 32'd5);
        chk("t6_rerun_pc",  32'(pc),  32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_alu_sequencer
`default_nettype wire
